// File: rtl/key_strobe_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : key_strobe_gen_pkg
//  Brief   : Shared FSM encodings, default timing constants and width helper
//            for the key strobe generator.
//  Rev     : 1.0  initial release
// ============================================================================
package key_strobe_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_e;

    // Board build: 20 ms debounce, 0.5 s auto-repeat at 50 MHz
    localparam int unsigned c_DEB_BOARD = 1_000_000;
    localparam int unsigned c_REP_BOARD = 25_000_000;
    localparam int unsigned c_DEB_SIM   = 4;
    localparam int unsigned c_REP_SIM   = 10;

    function automatic int unsigned f_cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module  : key_debounce
//  Brief   : One key: 2-flop synchronizer, polarity inversion and steady-level
//            counter; exposes the accepted level and its next value.
//  Rev     : 1.0  initial release
// ============================================================================
module key_debounce
    import key_strobe_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEB_BOARD
) (
    input  logic clk50m_i,
    input  logic rst_i,
    input  logic key_i,
    output logic stable_o,
    output logic stable_next_o
);

    localparam int unsigned     c_CW   = f_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            stable_q;
    logic            stable_d;
    logic [c_CW-1:0] cnt_q;
    logic [c_CW-1:0] cnt_d;
    logic            w_pressed;

    always_ff @(posedge clk50m_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= key_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Any cycle agreeing with the accepted level restarts the count
    always_comb begin
        w_pressed = ~sync2_q;
        stable_d  = stable_q;
        cnt_d     = '0;
        if (w_pressed != stable_q) begin
            if (cnt_q == c_LAST) begin
                stable_d = w_pressed;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign stable_o      = stable_q;
    assign stable_next_o = stable_d;

endmodule
`default_nettype wire

// File: rtl/key_strobe_gen.sv
`default_nettype none
// ============================================================================
//  Module  : key_strobe_gen
//  Brief   : Debounced active-low keys to pressed vector plus one-cycle enable
//            strobe on new presses and on auto-repeat while held.
//  Rev     : 1.0  initial release
// ============================================================================
module key_strobe_gen
    import key_strobe_gen_pkg::*;
#(
    parameter int unsigned KEY_W           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = c_DEB_BOARD,
    parameter int unsigned REPEAT_CYCLES   = c_REP_BOARD
) (
    input  logic             clk50m_i,
    input  logic             rst_i,
    input  logic [KEY_W-1:0] key_i,
    output logic [KEY_W-1:0] data_o,
    output logic             enable_o,
    output logic             busy_o
);

    localparam int unsigned     c_TW       = f_cnt_w(REPEAT_CYCLES);
    localparam logic [c_TW-1:0] c_REP_LAST = c_TW'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
    localparam logic            c_REP_EN   = (REPEAT_CYCLES != 0);

    logic [KEY_W-1:0] w_stable;
    logic [KEY_W-1:0] w_stable_next;
    logic             w_press_evt;

    state_e           state_q;
    state_e           state_d;
    logic [c_TW-1:0]  timer_q;
    logic [c_TW-1:0]  timer_d;
    logic [KEY_W-1:0] data_q;
    logic [KEY_W-1:0] data_d;
    logic             enable_q;
    logic             enable_d;

    generate
        for (genvar g = 0; g < KEY_W; g++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk50m_i      (clk50m_i),
                .rst_i         (rst_i),
                .key_i         (key_i[g]),
                .stable_o      (w_stable[g]),
                .stable_next_o (w_stable_next[g])
            );
        end
    endgenerate

    assign w_press_evt = |(w_stable_next & ~w_stable);

    always_ff @(posedge clk50m_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            data_q   <= '0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            data_q   <= data_d;
            enable_q <= enable_d;
        end
    end

    // Release-all beats a new press, which beats repeat expiry
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        data_d   = data_q;
        enable_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_press_evt) begin
                    state_d  = ST_HELD;
                    enable_d = 1'b1;
                    data_d   = w_stable_next;
                    timer_d  = '0;
                end
            end
            ST_HELD: begin
                if (w_stable_next == '0) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (w_press_evt) begin
                    enable_d = 1'b1;
                    data_d   = w_stable_next;
                    timer_d  = '0;
                end else if (c_REP_EN) begin
                    if (timer_q == c_REP_LAST) begin
                        enable_d = 1'b1;
                        data_d   = w_stable_next;
                        timer_d  = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign data_o   = data_q;
    assign enable_o = enable_q;
    assign busy_o   = (state_q == ST_HELD);

endmodule
`default_nettype wire
